// File: rtl/mut_mem_param.sv
// mut_mem_param -- parametrised memory-under-test model for the PMBIST datapath.
//
// Behavioural word array of 2**ADDR_WIDTH x DATA_WIDTH with:
//   * command decode (cmd_in[1:0]: 01 write, 10 read, 00 no-op, 11 illegal)
//   * RD_LATENCY-deep registered read pipeline with a one-cycle rd_valid strobe
//   * saturating write/read access counters and a sticky illegal-command flag
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (array contents are not reset)
//   cmd_valid  qualifies cmd_in
//   cmd_in     march command; only bits [1:0] are decoded
//   addr_in    word address
//   data_in    write data
//   data_out   registered read data, holds while rd_valid is low
//   rd_valid   one-cycle pulse marking a new data_out word
//   wr_count   accepted writes, saturating
//   rd_count   accepted reads, saturating
//   cmd_err    sticky, set by a qualified 2'b11 command
//
// Optional build macro MUT_FAULT_INJECT_EN adds flt_en / flt_addr / flt_bit /
// flt_type inputs that corrupt a single bit of a single address
// (00 stuck-at-0, 01 stuck-at-1, 10 transition-up fail, 11 no fault).
module mut_mem_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int CMD_WIDTH  = 4,
  parameter int RD_LATENCY = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [CMD_WIDTH-1:0]  cmd_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  cmd_err
`ifdef MUT_FAULT_INJECT_EN
  ,
  input  logic                  flt_en,
  input  logic [ADDR_WIDTH-1:0] flt_addr,
  input  logic [((DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1)-1:0] flt_bit,
  input  logic [1:0]            flt_type
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("mut_mem_param: RD_LATENCY must be in 1..4");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Command decode; upper command bits are don't-care.
  logic wr_acc, rd_acc, ill_cmd;
  assign wr_acc  = cmd_valid && (cmd_in[1:0] == 2'b01);
  assign rd_acc  = cmd_valid && (cmd_in[1:0] == 2'b10);
  assign ill_cmd = cmd_valid && (cmd_in[1:0] == 2'b11);

  logic unused_cmd;
  assign unused_cmd = ^cmd_in;

  // Write/read data paths, optionally corrupted by the fault model.
  logic [DATA_WIDTH-1:0] wdata, rdata;
  always_comb begin
    wdata = data_in;
    rdata = mem[addr_in];
`ifdef MUT_FAULT_INJECT_EN
    if (flt_en && (flt_addr == addr_in)) begin
      case (flt_type)
        2'b00: begin
          wdata[flt_bit] = 1'b0;
          rdata[flt_bit] = 1'b0;
        end
        2'b01: begin
          wdata[flt_bit] = 1'b1;
          rdata[flt_bit] = 1'b1;
        end
        // A cell that cannot rise keeps 0 whatever is written.
        2'b10: if (!mem[addr_in][flt_bit]) wdata[flt_bit] = 1'b0;
        default: ;
      endcase
    end
`endif
  end

  // Array: no reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[addr_in] <= wdata;
  end

  // Read pipeline. Stage RD_LATENCY-1 is the output register; the chains
  // prepend the incoming read so stage i loads chain[i] for any latency.
  logic [RD_LATENCY-1:0]                 vld_q;
  logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] dat_q;
  logic [RD_LATENCY:0]                   vld_pipe;
  logic [RD_LATENCY:0][DATA_WIDTH-1:0]   dat_pipe;
  assign vld_pipe = {vld_q, rd_acc};
  assign dat_pipe = {dat_q, rdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_pipe[RD_LATENCY-1:0];
      for (int i = 0; i < RD_LATENCY; i++) begin
        // Output stage only reloads on a valid word so data_out holds.
        if (i < RD_LATENCY-1 || vld_pipe[i]) dat_q[i] <= dat_pipe[i];
      end
    end
  end

  assign data_out = dat_q[RD_LATENCY-1];
  assign rd_valid = vld_q[RD_LATENCY-1];

  // Saturating counters and sticky error flag.
  logic [CNT_WIDTH-1:0] wr_cnt_q, rd_cnt_q;
  logic                 cmd_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      if (wr_acc && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 1'b1;
      if (rd_acc && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (ill_cmd) cmd_err_q <= 1'b1;
    end
  end

  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: doc/mut_mem_param.md
Name: mut_mem_param

Overview:
Parametrised memory-under-test model for the PMBIST datapath. It replaces the fixed single-port 32K wrapper with a behavioural array of configurable width and depth, a configurable registered read latency, explicit read/write command decode with a read-valid strobe, and saturating access counters. It sits between the march-sequence controller and the comparator/response analyser, and is driven directly by the BIST address and data generators.

Parameters:
DATA_WIDTH, 8, data word width in bits (1..64)
ADDR_WIDTH, 12, address width; depth = 2**ADDR_WIDTH words
CMD_WIDTH, 4, width of the march command field; only bits [1:0] are decoded, upper bits are ignored
RD_LATENCY, 1, clock cycles from read command to data_out/rd_valid (legal 1..4)
CNT_WIDTH, 16, width of the read and write access counters

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command qualifier; cmd_in is ignored when low
cmd_in  input  CMD_WIDTH  bit0 = write, bit1 = read
addr_in  input  ADDR_WIDTH  word address
data_in  input  DATA_WIDTH  write data
data_out  output  DATA_WIDTH  read data, registered
rd_valid  output  1  one-cycle pulse marking valid data_out
wr_count  output  CNT_WIDTH  number of accepted writes, saturating
rd_count  output  CNT_WIDTH  number of accepted reads, saturating
cmd_err  output  1  sticky flag; set when cmd_valid is high with cmd_in[1:0]==2'b11

Behaviour:
- Reset (async assert, sync release):
  - data_out, rd_valid, wr_count, rd_count, cmd_err and all pipeline stages go to 0.
  - Array contents are NOT reset.
- Command decode, sampled on the rising edge when cmd_valid=1:
  - 2'b01 = write: mem[addr_in] <= data_in.
  - 2'b10 = read.
  - 2'b00 = no-op.
  - 2'b11 = illegal: no array access, counters unchanged, cmd_err set and held until rst.
- Read pipeline:
  - A read in cycle N presents mem[addr_in] on data_out with rd_valid=1 after the rising edge of cycle N+RD_LATENCY.
  - Implemented as a RD_LATENCY-deep shift of {valid, data}; back-to-back reads every cycle are supported with no bubbles.
  - data_out holds its last value when rd_valid=0.
- Read-after-write: a write to address A in cycle N followed by a read of A in cycle N+1 returns the new data. There is no same-cycle read and write.
- Counters:
  - wr_count increments on each accepted write; rd_count increments on each accepted read.
  - Both saturate at all-ones and never wrap.
- Addressing: full range 0..2**ADDR_WIDTH-1, no aliasing. With ADDR_WIDTH=12 the top address is 0xFFF.
- RD_LATENCY outside 1..4: elaboration error via a generate-time check.
- Reset during reads: in-flight reads are discarded and rd_valid stays 0 after reset release until a new read completes.

Optional Feature:
Macro MUT_FAULT_INJECT_EN.
- Defined: adds these inputs:
  - flt_en (1)
  - flt_addr (ADDR_WIDTH)
  - flt_bit (clog2 DATA_WIDTH)
  - flt_type (2): 00 stuck-at-0, 01 stuck-at-1, 10 transition-up fail (0->1 write ignored on that bit), 11 reserved = no fault
- Fault behaviour while flt_en=1:
  - Writes to flt_addr are altered on bit flt_bit per flt_type before storage.
  - Reads of flt_addr force that bit for stuck-at types.
  - Fault inputs are sampled every cycle; no latching.
- Not defined: the ports are absent and the array behaves fault-free. The command, latency and counter behaviour above is identical in both builds.

Test Plan:
1. Reset, then with RD_LATENCY=1 write 0xA5 to 0x000 and read 0x000 -> data_out=0xA5, rd_valid high exactly 1 cycle after the read, wr_count=1, rd_count=1.
2. RD_LATENCY=3: write 0x00..0x0F to addresses 0..15, then issue 16 back-to-back reads -> 16 consecutive rd_valid pulses starting 3 cycles after the first read, data 0x00..0x0F in order.
3. Write 0x3C to 0xFFF, then read 0xFFF in the next cycle -> 0x3C, and address 0x000 is unchanged (no aliasing at the top address).
4. cmd_in=4'b0011 with cmd_valid=1 -> cmd_err=1 and stays 1; counters and array unchanged. cmd_in=4'b1110 -> decoded as a read.
5. Issue a read, assert rst one cycle later for 2 cycles -> rd_valid never pulses for that read; outputs are 0; a previously written location still reads back its old value after reset.
6. With MUT_FAULT_INJECT_EN, flt_en=1, flt_addr=0x010, flt_bit=2, flt_type=01: write 0x00 to 0x010 and read it -> 0x04. With flt_type=10: write 0xFF over 0x00 -> reads back 0xFB.
